pwm_capture: RTL and testbench

//  Measures an external PWM waveform: high time and period, in prescaled ticks.

---
 rtl/pwm_capture_pkg.sv | 15 +
 rtl/pwm_capture_if.sv | 12 +
 rtl/pwm_capture_sync_edge.sv | 31 +++
 rtl/pwm_capture.sv | 196 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types and field offsets for the PWM capture block.
// Config word layout: divval in the low field, timeout in the high field.
package pwm_capture_pkg;

    localparam int CAP_CNT_W   = 16;
    localparam int CFG_DIV_LSB = 0;
    localparam int CFG_TO_LSB  = 16;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } cap_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Result channel of the PWM capture block: {period, high} with valid/ready.
// The capture block is the master (source); the consumer is the slave.
interface pwm_capture_if #(parameter int CNT_W = 16);

    logic [2*CNT_W-1:0] meas_out;
    logic               meas_valid;
    logic               meas_ready;

    modport master (output meas_out, output meas_valid, input meas_ready);
    modport slave  (input meas_out, input meas_valid, output meas_ready);

endinterface

// File: rtl/pwm_capture_sync_edge.sv
// Synchroniser for an asynchronous level plus one-cycle rise/fall pulses.
// Reusable by any block that needs edges of an external input.
module pwm_capture_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_level_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_level_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_level_d;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_level_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an external PWM input in prescaled ticks,
// flags stuck inputs and dropped results, and offers results on valid/ready.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = CAP_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       i_config_in,
    input  logic              i_pwm_in,
    pwm_capture_if.master     bus,
    output logic              o_overrun,
    output logic              o_stuck,
    output logic              o_stuck_level
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic             w_pwm_s;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_divval;
    logic [CNT_W-1:0] w_timeout_val;

    cap_state_t       r_state;
    cap_state_t       w_state_next;

    logic [CNT_W-1:0] r_pre;
    logic [CNT_W-1:0] w_pre_cur;
    logic             w_tick;

    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_edge;
    logic [CNT_W-1:0] w_tick_init;

    logic             w_timeout;
    logic             w_start;
    logic             w_capture;
    logic             w_high_en;
    logic             w_period_en;
    logic             w_edge_en;
    logic             w_stuck_set;

    logic [2*CNT_W-1:0] r_meas;
    logic               r_valid;
    logic               r_overrun;
    logic               r_stuck;
    logic               r_stuck_level;

    pwm_capture_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (i_pwm_in),
        .o_level (w_pwm_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_divval      = i_config_in[CFG_DIV_LSB +: CNT_W];
    assign w_timeout_val = i_config_in[CFG_TO_LSB +: CNT_W];

    // The rise cycle is clock 1 of a period, so the prescaler phase is forced
    // to zero combinationally on rise; >= recovers at once if divval shrinks.
    always_comb begin
        w_pre_cur   = w_rise ? '0 : r_pre;
        w_tick      = (w_pre_cur >= w_divval);
        w_tick_init = w_tick ? ONE : '0;
        w_timeout   = (w_timeout_val != '0) && (r_edge == w_timeout_val);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else begin
            r_pre <= w_tick ? '0 : w_pre_cur + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_RISE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_RISE: if (w_rise) w_state_next = MEAS_HIGH;
            MEAS_HIGH: begin
                if (w_timeout)   w_state_next = WAIT_RISE;
                else if (w_fall) w_state_next = MEAS_LOW;
            end
            MEAS_LOW: begin
                if (w_timeout)   w_state_next = WAIT_RISE;
                else if (w_rise) w_state_next = MEAS_HIGH;
            end
            default: w_state_next = WAIT_RISE;
        endcase
    end

    // A tick landing on the fall cycle belongs to the low phase only.
    always_comb begin
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_high_en   = 1'b0;
        w_period_en = 1'b0;
        w_edge_en   = 1'b0;
        w_stuck_set = 1'b0;
        case (r_state)
            WAIT_RISE: w_start = w_rise;
            MEAS_HIGH: begin
                w_stuck_set = w_timeout;
                w_high_en   = !w_timeout && w_tick && !w_fall;
                w_period_en = !w_timeout && w_tick;
                w_edge_en   = !w_timeout && w_tick;
            end
            MEAS_LOW: begin
                w_stuck_set = w_timeout;
                w_capture   = !w_timeout && w_rise;
                w_start     = !w_timeout && w_rise;
                w_period_en = !w_timeout && w_tick;
                w_edge_en   = !w_timeout && w_tick;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high   <= '0;
            r_period <= '0;
        end else if (w_start) begin
            r_high   <= w_tick_init;
            r_period <= w_tick_init;
        end else begin
            if (w_high_en && r_high != ALL_ONES)     r_high   <= r_high + ONE;
            if (w_period_en && r_period != ALL_ONES) r_period <= r_period + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge <= '0;
        end else if (w_rise || w_fall) begin
            r_edge <= w_tick_init;
        end else if (w_edge_en && r_edge != ALL_ONES) begin
            r_edge <= r_edge + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stuck       <= 1'b0;
            r_stuck_level <= 1'b0;
        end else if (w_stuck_set) begin
            r_stuck       <= 1'b1;
            r_stuck_level <= w_pwm_s;
        end else if (w_rise) begin
            r_stuck       <= 1'b0;
        end
    end

    // One-entry result register: a capture is dropped only if the previous
    // result is still pending and not being accepted this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meas    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_capture) begin
            if (!r_valid || bus.meas_ready) begin
                r_meas  <= {r_period, r_high};
                r_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && bus.meas_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.meas_out   = r_meas;
    assign bus.meas_valid = r_valid;
    assign o_overrun      = r_overrun;
    assign o_stuck        = r_stuck;
    assign o_stuck_level  = r_stuck_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM patterns, collects accepted
// results into a queue and compares them against hand-computed values.
module tb_pwm_capture;

    logic        clk;
    logic        rst_n;
    logic [31:0] config_in;
    logic        pwm_in;
    logic        overrun;
    logic        stuck;
    logic        stuck_level;

    int checks;
    int errors;
    logic [31:0] results[$];

    pwm_capture_if #(.CNT_W(16)) bus ();

    pwm_capture #(
        .CNT_W       (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_config_in   (config_in),
        .i_pwm_in      (pwm_in),
        .bus           (bus.master),
        .o_overrun     (overrun),
        .o_stuck       (stuck),
        .o_stuck_level (stuck_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every result handed over on the valid/ready channel.
    always @(negedge clk) begin
        if (rst_n && bus.meas_valid && bus.meas_ready) results.push_back(bus.meas_out);
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResults(input string tag, input int n, input logic [31:0] exp);
        checkOutput({tag, "_count"}, 32'(results.size()), 32'(n));
        for (int i = 0; i < results.size(); i++) checkOutput({tag, "_value"}, results[i], exp);
    endtask

    task automatic applyStimulus(input int highClk, input int lowClk, input int periods);
        repeat (periods) begin
            pwm_in = 1'b1;
            cycles(highClk);
            pwm_in = 1'b0;
            cycles(lowClk);
        end
    endtask

    task automatic resetDut(input logic [15:0] divval, input logic [15:0] timeout, input logic ready);
        rst_n          = 1'b0;
        pwm_in         = 1'b0;
        config_in      = {timeout, divval};
        bus.meas_ready = ready;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        results.delete();
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        pwm_in         = 1'b0;
        config_in      = '0;
        bus.meas_ready = 1'b1;
        #1;
        checkOutput("reset_valid", {31'd0, bus.meas_valid}, 32'd0);
        checkOutput("reset_meas", bus.meas_out, 32'd0);
        checkOutput("reset_flags", {29'd0, overrun, stuck, stuck_level}, 32'd0);

        $display("[TB] basic 3 high / 5 low, divval 0");
        resetDut(16'd0, 16'd0, 1'b1);
        applyStimulus(3, 5, 4);
        cycles(4);
        checkResults("basic", 3, {16'd8, 16'd3});

        $display("[TB] prescaled 10 high / 30 low, divval 3");
        resetDut(16'd3, 16'd0, 1'b1);
        applyStimulus(10, 30, 3);
        cycles(4);
        checkResults("prescaled", 2, {16'd10, 16'd2});

        $display("[TB] backpressure and overrun");
        resetDut(16'd0, 16'd0, 1'b0);
        applyStimulus(3, 5, 1);
        applyStimulus(2, 4, 1);
        checkOutput("bp_first_valid", {31'd0, bus.meas_valid}, 32'd1);
        checkOutput("bp_first_meas", bus.meas_out, {16'd8, 16'd3});
        checkOutput("bp_no_overrun", {31'd0, overrun}, 32'd0);
        applyStimulus(2, 4, 1);
        cycles(4);
        checkOutput("bp_held_meas", bus.meas_out, {16'd8, 16'd3});
        checkOutput("bp_overrun", {31'd0, overrun}, 32'd1);
        bus.meas_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_valid_drops", {31'd0, bus.meas_valid}, 32'd0);
        checkOutput("bp_overrun_sticky", {31'd0, overrun}, 32'd1);
        checkResults("bp_accepted", 1, {16'd8, 16'd3});

        $display("[TB] stuck detection, timeout 5");
        resetDut(16'd0, 16'd5, 1'b1);
        applyStimulus(20, 4, 1);
        checkOutput("stuck_set", {31'd0, stuck}, 32'd1);
        checkOutput("stuck_level_high", {31'd0, stuck_level}, 32'd1);
        checkOutput("stuck_no_valid", {31'd0, bus.meas_valid}, 32'd0);
        applyStimulus(3, 4, 1);
        checkOutput("stuck_cleared", {31'd0, stuck}, 32'd0);
        checkResults("stuck_first_rise", 0, 32'd0);
        applyStimulus(3, 12, 1);
        checkResults("stuck_second_rise", 1, {16'd7, 16'd3});
        checkOutput("stuck_low_set", {31'd0, stuck}, 32'd1);
        checkOutput("stuck_level_low", {31'd0, stuck_level}, 32'd0);

        $display("[TB] generator loopback, divval 1");
        resetDut(16'd1, 16'd0, 1'b1);
        applyStimulus(8, 12, 4);
        cycles(4);
        checkResults("loopback", 3, {16'd10, 16'd4});

        $display("[TB] reset mid measurement");
        resetDut(16'd0, 16'd0, 1'b0);
        applyStimulus(3, 5, 3);
        applyStimulus(3, 2, 1);
        checkOutput("midrst_pre_valid", {31'd0, bus.meas_valid}, 32'd1);
        checkOutput("midrst_pre_overrun", {31'd0, overrun}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'd0, bus.meas_valid}, 32'd0);
        checkOutput("midrst_meas", bus.meas_out, 32'd0);
        checkOutput("midrst_flags", {29'd0, overrun, stuck, stuck_level}, 32'd0);
        cycles(3);
        rst_n          = 1'b1;
        bus.meas_ready = 1'b1;
        cycles(2);
        results.delete();
        applyStimulus(3, 5, 1);
        checkOutput("midrst_first_valid", {31'd0, bus.meas_valid}, 32'd0);
        checkResults("midrst_first_rise", 0, 32'd0);
        applyStimulus(3, 5, 1);
        checkResults("midrst_second_rise", 1, {16'd8, 16'd3});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
